gf2_row_skew_feeder: RTL
========================

// Module: gf2_row_skew_feeder
// PURPOSE
//  Upstream feeder for the single-pass GF(2) systolic systemizer array.
//  - Accepts matrix rows over a valid/ready handshake.
//  - Drives the array's top-edge data_in/start_in columns with a diagonal skew:
//    column j lags column 0 by j cycles.
//  - The array has no stall path. Once a matrix starts, the feeder streams it
//    without gaps, then flushes zeros until the skew has fully drained.
// PARAMETERS
//  N     8  matrix columns = array width = output columns
//  ROWS  8  rows per matrix; ROWS >= 1
// PORTS
//  clk         in   1     system clock; all state updates on rising edge
//  rst_n       in   1     asynchronous, active-low reset
//  go          in   1     1-cycle pulse that starts one matrix; sampled only in IDLE
//  row_valid   in   1     row_data holds a valid row
//  row_ready   out  1     feeder accepts a row this cycle
//  row_data    in   N     row bits; bit j feeds column j
//  data_out    out  N     skewed bit per column, to the array's data_in
//  start_out   out  N     per-column start; high while that column carries row 0
//  busy        out  1     state != IDLE
//  done        out  1     1-cycle pulse after the flush completes
//  underrun    out  1     a STREAM cycle passed with no row accepted
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; row counter and flush counter = 0.
//   - All skew stages = 0, so data_out, start_out = 0.
//   - row_ready, busy, done, underrun = 0.
//  Skew line:
//   - Column j is a chain of j+1 flops for data and j+1 flops for start.
//   - Stage 0 of column j loads row_data[j] on acceptance, else 0.
//   - Start stage 0 loads 1 only when accepting row 0.
//   - A row accepted at edge t appears on data_out[j] during cycle t+1+j.
//   - Outputs come straight from registers; no combinational path from row_data.
//  FSM:
//   - IDLE:   row_ready=0. go=1 -> STREAM, row_cnt=0. go is ignored in every other state.
//   - STREAM: row_ready=1.
//       - Accept (row_valid & row_ready) -> row_cnt+1.
//       - Accept with row_cnt==ROWS-1 -> FLUSH, flush_cnt=0.
//       - row_valid=0 -> zeros enter stage 0; row_cnt holds; underrun asserted.
//         The array sees a zero row; upstream must not do this.
//   - FLUSH:  row_ready=0; zeros enter stage 0; flush_cnt+1 each cycle.
//       - flush_cnt==N-1 -> DONE. This takes N cycles, so the last row bit has
//         left column N-1.
//   - DONE:   done=1 for one cycle; -> IDLE. Skew line is all zero here.
//  Counters:
//   - row_cnt width clog2(ROWS+1).
//   - flush_cnt width clog2(N+1).
//   - Neither wraps; both are cleared on entry to their state.
//  Boundaries:
//   - ROWS=1: the first accept goes straight to FLUSH.
//   - go in the same cycle as DONE is ignored; a new go in IDLE is required.
//   - rst_n low mid-stream discards in-flight bits immediately; start_out drops to 0.
//   - row_valid held high in IDLE/FLUSH/DONE: no accept, no effect.
// CONFIGURATION
//  Macro FEEDER_UNDERRUN_STICKY_EN:
//   - Defined: underrun is sticky. It sets on any STREAM cycle without an accept,
//     clears only on reset or on the go that starts the next matrix.
//   - Undefined: underrun is a registered 1-cycle pulse, asserted the cycle after
//     each STREAM cycle without an accept.
// TESTING
//  - Reset: hold rst_n=0 mid-FLUSH -> all outputs 0 asynchronously; IDLE after release.
//  - N=4, ROWS=4, go, rows 0xF,0x1,0x2,0x8 back-to-back, first accepted at edge t:
//      - data_out[0] = 1,1,0,0 in cycles t+1..t+4.
//      - data_out[3] = 1,0,0,1 in cycles t+4..t+7.
//      - start_out[j] high only in cycle t+1+j.
//  - Same run: done pulses exactly once, at cycle t+3+N+1; busy drops the next
//    cycle; data_out==0 from t+8 on.
//  - row_valid low for 2 cycles after row 1:
//      - zero rows are inserted; row_cnt holds.
//      - STICKY_EN: underrun stays 1 until the next go.
//      - Without it: exactly 2 underrun pulses.
//  - go while busy, and row_valid high in IDLE -> no state change, row_ready=0,
//    no rows consumed.
//  - ROWS=1, N=8, row 0xA5 -> column j outputs bit j of 0xA5 in cycle t+1+j;
//    done 8 cycles after FLUSH entry.

Source files
------------

// File: rtl/gf2_row_skew_feeder.sv
// Row feeder for the GF(2) systolic systemizer: streams accepted rows into the top edge with a
// per-column diagonal skew, then flushes zeros. Optional macro FEEDER_UNDERRUN_STICKY_EN makes underrun sticky.
module gf2_row_skew_feeder #(
    parameter int N    = 8,
    parameter int ROWS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic         row_valid,
    output logic         row_ready,
    input  logic [N-1:0] row_data,
    output logic [N-1:0] data_out,
    output logic [N-1:0] start_out,
    output logic         busy,
    output logic         done,
    output logic         underrun
);

    localparam int RCW = $clog2(ROWS + 1);
    localparam int FCW = $clog2(N + 1);
    localparam logic [RCW-1:0] LAST_ROW   = RCW'(ROWS - 1);
    localparam logic [FCW-1:0] LAST_FLUSH = FCW'(N - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t         state, state_nx;
    logic [RCW-1:0] row_cnt;
    logic [FCW-1:0] flush_cnt;
    logic           accept;
    logic           miss;
    logic           first_row;

    assign accept    = row_valid && row_ready;
    assign miss      = (state == STREAM) && !row_valid;
    assign first_row = accept && (row_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        row_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go)
                    state_nx = STREAM;
            end
            STREAM: begin
                row_ready = 1'b1;
                if (row_valid && (row_cnt == LAST_ROW))
                    state_nx = FLUSH;
            end
            FLUSH: begin
                if (flush_cnt == LAST_FLUSH)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == IDLE && go)
                row_cnt <= '0;
            else if (accept)
                row_cnt <= row_cnt + 1'b1;

            if (state == STREAM)
                flush_cnt <= '0;
            else if (state == FLUSH)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

`ifdef FEEDER_UNDERRUN_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun <= 1'b0;
        else if (state == IDLE && go)
            underrun <= 1'b0;
        else if (miss)
            underrun <= 1'b1;
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun <= 1'b0;
        else
            underrun <= miss;
    end
`endif

    // Column j is a j+1 deep shift chain; stage 0 sees zero unless a row is accepted.
    for (genvar j = 0; j < N; j++) begin : g_col
        logic [j:0] d_sh;
        logic [j:0] s_sh;
        if (j == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_sh <= '0;
                    s_sh <= '0;
                end else begin
                    d_sh <= accept & row_data[j];
                    s_sh <= first_row;
                end
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_sh <= '0;
                    s_sh <= '0;
                end else begin
                    d_sh <= {d_sh[j-1:0], accept & row_data[j]};
                    s_sh <= {s_sh[j-1:0], first_row};
                end
            end
        end
        assign data_out[j]  = d_sh[j];
        assign start_out[j] = s_sh[j];
    end

endmodule
